// File: rtl/vector_regfile_mask.sv
// Vector register file with per-element write masking from register 0.
// A reset starts a one-register-per-cycle clear sweep; the file is busy until it finishes.
module vector_regfile_mask #(
  parameter int VLEN  = 4,
  parameter int SEW   = 32,
  parameter int NREGS = 32,
  localparam int RW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RW-1:0]       rs1,
  input  logic [RW-1:0]       rs2,
  input  logic [RW-1:0]       wr_reg,
  input  logic [VLEN*SEW-1:0] write_data,
  input  logic                reg_write,
  input  logic                vm,
  output logic [VLEN*SEW-1:0] rd1,
  output logic [VLEN*SEW-1:0] rd2,
  output logic [VLEN-1:0]     v0_mask,
  output logic                busy
);

  // state    | meaning
  // ST_CLEAR | sweeping register cnt to zero, writes dropped, reads forced to zero
  // ST_IDLE  | normal read/write operation
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                state;
  logic [RW-1:0]         cnt;
  logic [VLEN*SEW-1:0]   regs [NREGS];
  logic [VLEN-1:0]       we;
  logic [VLEN-1:0]       mask_raw;

  assign busy = (state == ST_CLEAR);

  for (genvar e = 0; e < VLEN; e++) begin : g_elem
    assign mask_raw[e] = regs[0][e*SEW];
    assign we[e]       = reg_write & ~busy & (vm | mask_raw[e]);
    assign v0_mask[e]  = ~busy & mask_raw[e];

    // Write-first bypass: an enabled element being written this cycle is visible immediately.
    assign rd1[e*SEW +: SEW] = busy ? {SEW{1'b0}} :
                               ((rs1 == wr_reg) && we[e]) ? write_data[e*SEW +: SEW] :
                               regs[rs1][e*SEW +: SEW];
    assign rd2[e*SEW +: SEW] = busy ? {SEW{1'b0}} :
                               ((rs2 == wr_reg) && we[e]) ? write_data[e*SEW +: SEW] :
                               regs[rs2][e*SEW +: SEW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          regs[cnt] <= '0;
          cnt       <= cnt + 1'b1;
          if (cnt == RW'(NREGS - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          for (int e = 0; e < VLEN; e++) begin
            if (we[e]) regs[wr_reg][e*SEW +: SEW] <= write_data[e*SEW +: SEW];
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule
